// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and constants for the execute result stage
package ex_pkg;

    localparam int EX_WIDTH = 64;
    localparam int EX_RD_W  = 5;

    // Bit positions inside the {N,Z,V,C} flag vector
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int V_IDX = 1;
    localparam int C_IDX = 0;

    // A64 branch condition codes
    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        HS = 4'h2,
        LO = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    // One buffered execute result headed for the memory stage
    typedef struct packed {
        logic [EX_WIDTH-1:0] result;
        logic [EX_RD_W-1:0]  rd;
        logic                reg_write;
    } ex_entry_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid buffer carrying execute results
module pipe_skid_reg
    import ex_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      in_valid,
    output logic      in_ready,
    input  ex_entry_t in_data,
    output logic      out_valid,
    input  logic      out_ready,
    output ex_entry_t out_data
);

    logic      main_valid_q, main_valid_d;
    logic      skid_valid_q, skid_valid_d;
    ex_entry_t main_q, main_d;
    ex_entry_t skid_q, skid_d;
    logic      accept;
    logic      drain;

    // in_ready comes straight from a flop so upstream never sees out_ready combinationally
    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

    // Next-state: main refills from skid first, otherwise from the input; skid catches input when main is stuck
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        accept       = in_valid && !skid_valid_q;
        drain        = main_valid_q && out_ready;
        if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_data;
                end
            end
        end else if (accept) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end
    end

    // Occupancy flags; reset drops whatever is held
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload registers need no reset; they are qualified by the valid flags
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/ex_result_stage.sv
// rtl/ex_result_stage.sv - execute output register, NZVC flag register and condition evaluator
module ex_result_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH,
    parameter int RD_W  = EX_RD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_flags,
    input  logic             in_set_flags,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_reg_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_reg_write,
    output logic [3:0]       flags_nzvc,
    input  logic [3:0]       cond,
    output logic             cond_true
);

    ex_entry_t  in_entry;
    ex_entry_t  out_entry;
    logic [3:0] flags_q, flags_d;
    logic       f_n, f_z, f_v, f_c;

    // Pack the ALU outputs into a buffer entry
    always_comb begin
        in_entry.result    = in_result;
        in_entry.rd        = in_rd;
        in_entry.reg_write = in_reg_write;
    end

    pipe_skid_reg u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_result    = out_entry.result;
    assign out_rd        = out_entry.rd;
    assign out_reg_write = out_entry.reg_write;

    // Flags update only when a flag-setting instruction is actually accepted
    always_comb begin
        flags_d = flags_q;
        if (in_valid && in_ready && in_set_flags) begin
            flags_d = in_flags;
        end
    end

    // Architectural NZVC register
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_nzvc = flags_q;
    assign f_n        = flags_q[N_IDX];
    assign f_z        = flags_q[Z_IDX];
    assign f_v        = flags_q[V_IDX];
    assign f_c        = flags_q[C_IDX];

    // Condition evaluation sees only the registered flags; a same-cycle flag write is not forwarded
    always_comb begin
        cond_true = 1'b1;
        case (cond_e'(cond))
            EQ:      cond_true = f_z;
            NE:      cond_true = !f_z;
            HS:      cond_true = f_c;
            LO:      cond_true = !f_c;
            MI:      cond_true = f_n;
            PL:      cond_true = !f_n;
            VS:      cond_true = f_v;
            VC:      cond_true = !f_v;
            HI:      cond_true = f_c && !f_z;
            LS:      cond_true = !(f_c && !f_z);
            GE:      cond_true = (f_n == f_v);
            LT:      cond_true = (f_n != f_v);
            GT:      cond_true = !f_z && (f_n == f_v);
            LE:      cond_true = !(!f_z && (f_n == f_v));
            AL:      cond_true = 1'b1;
            NV:      cond_true = 1'b1;
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ex_result_stage.sv
// tb/tb_ex_result_stage.sv - self-checking bench for ex_result_stage
module tb_ex_result_stage;
    import ex_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [3:0]  in_flags;
    logic        in_set_flags;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [3:0]  flags_nzvc;
    logic [3:0]  cond;
    logic        cond_true;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } exp_entry_t;

    exp_entry_t  model_q[$];
    logic [3:0]  m_flags;

    ex_result_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_flags      (in_flags),
        .in_set_flags  (in_set_flags),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .flags_nzvc    (flags_nzvc),
        .cond          (cond),
        .cond_true     (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare every output with the model, then step model and clock
    task automatic cycle(input logic iv, input logic [63:0] res, input logic [3:0] fl,
                         input logic sf, input logic [4:0] rd, input logic rw,
                         input logic ordy, input logic [3:0] cnd);
        logic       acc, drn;
        exp_entry_t e;
        in_valid     = iv;
        in_result    = res;
        in_flags     = fl;
        in_set_flags = sf;
        in_rd        = rd;
        in_reg_write = rw;
        out_ready    = ordy;
        cond         = cnd;
        #1;
        check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            check("out_result", out_result, model_q[0].result);
            check("out_rd", 64'(out_rd), 64'(model_q[0].rd));
            check("out_reg_write", 64'(out_reg_write), 64'(model_q[0].reg_write));
        end
        check("flags_nzvc", 64'(flags_nzvc), 64'(m_flags));
        check("cond_true", 64'(cond_true), 64'(ref_cond(cnd, m_flags)));
        acc = iv && (model_q.size() < 2);
        drn = (model_q.size() > 0) && ordy;
        if (drn) void'(model_q.pop_front());
        if (acc) begin
            e.result    = res;
            e.rd        = rd;
            e.reg_write = rw;
            model_q.push_back(e);
            if (sf) m_flags = fl;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        model_q.delete();
        m_flags = 4'b0000;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_set_flags = 1'b0;
        in_rd = '0; in_reg_write = 1'b0; out_ready = 1'b0; cond = 4'h0;
        m_flags = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_flags", 64'(flags_nzvc), 64'd0);
        check("rst_cond_eq", 64'(cond_true), 64'd0);
        cond = 4'h1;
        #1;
        check("rst_cond_ne", 64'(cond_true), 64'd1);

        // Single pass-through
        cycle(1'b1, 64'h5, 4'h0, 1'b0, 5'd3, 1'b1, 1'b1, 4'h0);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_out_result", out_result, 64'h5);
        check("t1_out_rd", 64'(out_rd), 64'd3);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        cycle(1'b0, 64'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b1, 4'h0);
        check("t1_drained", 64'(out_valid), 64'd0);

        // Fill under back-pressure, then release
        cycle(1'b1, 64'h1, 4'h0, 1'b0, 5'd1, 1'b1, 1'b0, 4'h0);
        cycle(1'b1, 64'h2, 4'h0, 1'b0, 5'd2, 1'b1, 1'b0, 4'h0);
        check("t2_full_in_ready", 64'(in_ready), 64'd0);
        check("t2_head_a", out_result, 64'h1);
        cycle(1'b0, 64'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b1, 4'h0);
        check("t2_head_b", out_result, 64'h2);
        check("t2_ready_back", 64'(in_ready), 64'd1);
        cycle(1'b0, 64'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b1, 4'h0);
        check("t2_empty", 64'(out_valid), 64'd0);

        // Flag write visible only after the edge
        cond = 4'h0;
        #1;
        check("t3_old_flags_eq", 64'(cond_true), 64'd0);
        cycle(1'b1, 64'h0, 4'b0110, 1'b1, 5'd4, 1'b1, 1'b1, 4'h0);
        check("t3_new_flags", 64'(flags_nzvc), 64'h6);
        check("t3_eq_true", 64'(cond_true), 64'd1);

        // Non-flag-setting instruction leaves flags alone; GT evaluation
        cycle(1'b1, 64'h7, 4'b1001, 1'b0, 5'd5, 1'b1, 1'b1, 4'hC);
        check("t4_flags_hold", 64'(flags_nzvc), 64'h6);
        cycle(1'b1, 64'h8, 4'b0000, 1'b1, 5'd6, 1'b1, 1'b1, 4'hC);
        check("t4_gt_0000", 64'(cond_true), 64'd1);
        cycle(1'b1, 64'h9, 4'b1000, 1'b1, 5'd7, 1'b1, 1'b1, 4'hC);
        check("t4_gt_1000", 64'(cond_true), 64'd0);
        cycle(1'b0, 64'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b1, 4'hC);

        // Reset while full
        cycle(1'b1, 64'h11, 4'h3, 1'b1, 5'd8, 1'b1, 1'b0, 4'h0);
        cycle(1'b1, 64'h12, 4'h0, 1'b0, 5'd9, 1'b1, 1'b0, 4'h0);
        check("t5_full", 64'(in_ready), 64'd0);
        do_reset();
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_flags", 64'(flags_nzvc), 64'd0);
        cycle(1'b1, 64'hABC, 4'h0, 1'b0, 5'd10, 1'b0, 1'b1, 4'h0);
        check("t5_after_push", out_result, 64'hABC);
        check("t5_after_valid", 64'(out_valid), 64'd1);

        // Randomized traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, {$urandom, $urandom}, 4'($urandom), 1'($urandom),
                  5'($urandom), 1'($urandom), ($urandom % 3) != 0, 4'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 64'h0, 4'h0, 1'b0, 5'd0, 1'b0, 1'b1, 4'($urandom));
        end
        check("final_empty", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
